// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Groups the keypad pin signals and the decoder-facing outputs of the
//   keypad scanner into one bundle.
//   master : scanner side (drives row_drive/row/col/key_valid/key_held,
//            receives col_in)
//   slave  : pins + decoder side (drives col_in, observes the rest)
//   Signals:
//     col_in    [3:0] raw keypad columns, active-low, asynchronous
//     row_drive [3:0] keypad row drive, one-cold
//     row       [3:0] one-hot row of the held key, 0000 when none
//     col       [3:0] one-hot column of the held key, 0000 when none
//     key_valid       one-cycle strobe per accepted press (and repeat)
//     key_held        high from acceptance until release is accepted
interface keypad_scanner_if;
    logic [3:0] col_in;
    logic [3:0] row_drive;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  col_in,
        output row_drive, row, col, key_valid, key_held
    );

    modport slave (
        output col_in,
        input  row_drive, row, col, key_valid, key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 keypad one row at a time, samples the (synchronized,
//   inverted) columns on the last cycle of each row dwell, debounces the
//   result and presents a stable one-hot {row, col} pair plus a one-cycle
//   key_valid strobe per accepted press.
//   Ports:
//     clk    : single clock
//     rst_n  : asynchronous active-low reset
//     kp     : keypad_scanner_if.master (col_in in; row_drive, row, col,
//              key_valid, key_held out)
//   Optional feature macro: KEYPAD_AUTOREPEAT_EN
//     defined   -> key_valid repeats after REPEAT_DELAY matching samples,
//                  then every REPEAT_RATE matching samples while held
//     undefined -> exactly one key_valid per press, REPEAT_* ignored
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE     = 8,
    parameter int REPEAT_DELAY = 400,
    parameter int REPEAT_RATE  = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_t;

    logic [3:0]       col_s1, col_s2;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       cols;
    logic             single;
    logic [3:0]       samp;

    state_t           state, state_n;
    logic [1:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       cand, cand_n;
    logic [3:0]       row_q, row_n;
    logic [3:0]       col_q, col_n;
    logic             valid_q, valid_n;
    logic             held_q, held_n;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    logic [REP_W-1:0] rep, rep_n;
    logic             rep_first, rep_first_n;
    logic [REP_W-1:0] rep_target;
`else
    // Repeat parameters are accepted for a uniform instantiation but have
    // no effect in this build.
    if (REPEAT_DELAY < 0 || REPEAT_RATE < 0) begin : g_repeat_unused
    end
`endif

    // Two-flop synchronizer and free-running dwell counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1  <= '0;
            col_s2  <= '0;
            div_cnt <= '0;
        end else begin
            col_s1  <= kp.col_in;
            col_s2  <= col_s1;
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

    assign tick   = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign cols   = ~col_s2;
    assign single = (cols != 4'b0000) && ((cols & (cols - 4'd1)) == 4'b0000);
    // Multi-key samples collapse to "none" so ghost patterns never match.
    assign samp   = single ? cols : 4'b0000;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_SCAN;
            idx     <= '0;
            cnt     <= '0;
            cand    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep       <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            cand    <= cand_n;
            row_q   <= row_n;
            col_q   <= col_n;
            valid_q <= valid_n;
            held_q  <= held_n;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep       <= rep_n;
            rep_first <= rep_first_n;
`endif
        end
    end

    // Next-state and output logic; everything moves only on a sample tick.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        cand_n  = cand;
        row_n   = row_q;
        col_n   = col_q;
        valid_n = 1'b0;
        held_n  = held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_n       = rep;
        rep_first_n = rep_first;
        rep_target  = rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_RATE - 1);
`endif
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (single) begin
                        // Row index freezes here until the key resolves.
                        cand_n  = cols;
                        cnt_n   = CNT_W'(1);
                        state_n = ST_DEBOUNCE;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (samp == cand) begin
                        if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                            row_n   = 4'b0001 << idx;
                            col_n   = cand;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            cnt_n   = '0;
                            cand_n  = '0;
                            state_n = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_n       = '0;
                            rep_first_n = 1'b1;
`endif
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end else begin
                        cand_n  = '0;
                        cnt_n   = '0;
                        idx_n   = idx + 2'd1;
                        state_n = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (samp == col_q) begin
                        cnt_n = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep == rep_target) begin
                            valid_n     = 1'b1;
                            rep_n       = '0;
                            rep_first_n = 1'b0;
                        end else begin
                            rep_n = rep + REP_W'(1);
                        end
`endif
                    end else begin
                        // Any other sample (none, other key, multi) counts
                        // toward release.
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_n       = '0;
                        rep_first_n = 1'b1;
`endif
                        if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                            row_n   = '0;
                            col_n   = '0;
                            held_n  = 1'b0;
                            cnt_n   = '0;
                            idx_n   = idx + 2'd1;
                            state_n = ST_SCAN;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = ST_SCAN;
                    cnt_n   = '0;
                    cand_n  = '0;
                end
            endcase
        end
    end

    assign kp.row_drive = ~(4'b0001 << idx);
    assign kp.row       = row_q;
    assign kp.col       = col_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3 (REPEAT_DELAY=5,
//   REPEAT_RATE=2 when built with KEYPAD_AUTOREPEAT_EN). A physical keypad
//   model turns a 16-bit pressed-key mask (bit r*4+c) plus row_drive into
//   col_in. Directed table records, hand-written corner sequences, and a
//   randomized run checked against a key-level reference model.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pressed = '0;

    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV(SD), .DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    // Keypad matrix: a column reads low if any pressed key in it sits on a
    // driven (low) row.
    always_comb begin
        logic [3:0] ci;
        ci = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[r*4+c] && !kp.row_drive[r]) ci[c] = 1'b0;
        kp.col_in = ci;
    end

    int n_pass = 0;
    int n_total = 0;
    int strobes = 0;

    always @(negedge clk) if (kp.key_valid === 1'b1) strobes++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model (one step per row dwell) ----------
    int m_idx, m_cand, m_run, m_key, m_gone, m_rep;
    bit m_first;

    function automatic void model_reset();
        m_idx = 0; m_cand = -1; m_run = 0; m_key = -1; m_gone = 0; m_rep = 0; m_first = 1;
    endfunction

    function automatic bit model_step(input logic [15:0] keys);
        logic [3:0] s;
        int n, c;
        bit st;
        s = keys[m_idx*4 +: 4];
        n = 0; c = -1; st = 0;
        for (int i = 0; i < 4; i++) if (s[i]) begin n++; c = i; end
        if (n != 1) c = -1;
        if (m_key >= 0) begin
            if (c >= 0 && c == m_key % 4) begin
                m_gone = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
                m_rep++;
                if (m_rep == (m_first ? RD : RR)) begin st = 1; m_rep = 0; m_first = 0; end
`endif
            end else begin
                m_rep = 0; m_first = 1;
                m_gone++;
                if (m_gone == DB) begin m_key = -1; m_gone = 0; m_idx = (m_idx + 1) % 4; end
            end
        end else if (m_cand >= 0) begin
            if (c == m_cand) begin
                m_run++;
                if (m_run == DB) begin
                    m_key = m_idx * 4 + m_cand; m_cand = -1; st = 1;
                    m_gone = 0; m_rep = 0; m_first = 1;
                end
            end else begin
                m_cand = -1; m_idx = (m_idx + 1) % 4;
            end
        end else if (c >= 0) begin
            m_cand = c; m_run = 1;
        end else begin
            m_idx = (m_idx + 1) % 4;
        end
        return st;
    endfunction

    // ---------------- helpers -------------------------------------------
    // One row dwell; returns #1 after the sampling edge.
    task automatic dwell();
        repeat (SD) @(posedge clk);
        #1;
    endtask

    // Reset with a given key set held; releases on a negedge so the next
    // dwell() call lands on the sampling edges.
    task automatic do_reset(input logic [15:0] keys);
        rst_n = 1'b0;
        pressed = keys;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [15:0] keys;
        int          dwells;
        int          n_valid;
        logic [3:0]  drive;
        logic [3:0]  row;
        logic [3:0]  col;
        logic        held;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int s0;
        bit st;
        logic [3:0] er, ec;

        // Key index = row*4 + col. Expected values traced from reset phase.
        tbl[0] = '{16'h0020, 8, 1, 4'b1101, 4'b0010, 4'b0010, 1'b1}; // key r1c1
        tbl[1] = '{16'h0000, 4, 0, 4'b0111, 4'b0000, 4'b0000, 1'b0}; // release
        tbl[2] = '{16'h0003, 10, 0, 4'b1101, 4'b0000, 4'b0000, 1'b0}; // ghost r0c0+r0c1
        tbl[3] = '{16'h0000, 2, 0, 4'b0111, 4'b0000, 4'b0000, 1'b0};
        tbl[4] = '{16'h0020, 6, 1, 4'b1101, 4'b0010, 4'b0010, 1'b1}; // key r1c1
        tbl[5] = '{16'h0220, 3, 0, 4'b1101, 4'b0010, 4'b0010, 1'b1}; // + r2c1 while held
        tbl[6] = '{16'h0000, 4, 0, 4'b0111, 4'b0000, 4'b0000, 1'b0};
        tbl[7] = '{16'h2000, 6, 1, 4'b0111, 4'b1000, 4'b0010, 1'b1}; // key r3c1
        tbl[8] = '{16'h0000, 4, 0, 4'b1101, 4'b0000, 4'b0000, 1'b0};

        // ---- reset values and row rotation ----
        rst_n = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        check("reset_out", {kp.row_drive, kp.row, kp.col, kp.key_valid, kp.key_held},
              {4'b1110, 4'b0000, 4'b0000, 1'b0, 1'b0});
        rst_n = 1'b1;
        check("rot0", kp.row_drive, 4'b1110);
        dwell(); check("rot1", kp.row_drive, 4'b1101);
        dwell(); check("rot2", kp.row_drive, 4'b1011);
        dwell(); check("rot3", kp.row_drive, 4'b0111);

        // ---- table-driven records ----
        do_reset('0);
        for (int i = 0; i < 9; i++) begin
            s0 = strobes;
            pressed = tbl[i].keys;
            repeat (tbl[i].dwells) dwell();
            check($sformatf("tbl%0d_out", i), {kp.row_drive, kp.row, kp.col, kp.key_held},
                  {tbl[i].drive, tbl[i].row, tbl[i].col, tbl[i].held});
            @(negedge clk);
            check($sformatf("tbl%0d_strobes", i), strobes - s0, tbl[i].n_valid);
        end

        // ---- bounce: candidate lost on a differing sample ----
        do_reset('0);
        s0 = strobes;
        dwell();                      // idx0 empty -> idx1
        pressed = 16'h0020; dwell();  // candidate r1c1
        pressed = 16'h0000; dwell();  // bounce -> back to SCAN, row advanced
        check("bounce_adv", {kp.row_drive, kp.key_held, kp.key_valid}, {4'b1011, 1'b0, 1'b0});
        for (int d = 4; d <= 11; d++) begin
            pressed = (d % 2 == 0) ? 16'h0020 : 16'h0000;
            dwell();
        end
        @(negedge clk);
        check("bounce_strobes", strobes - s0, 0);

        // ---- reset while held, then re-detection ----
        do_reset(16'h2000);
        repeat (6) dwell();
        check("mid_held", {kp.row, kp.col, kp.key_held}, {4'b1000, 4'b0010, 1'b1});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_reset_async", {kp.row_drive, kp.row, kp.col, kp.key_valid, kp.key_held},
              {4'b1110, 4'b0000, 4'b0000, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        s0 = strobes;
        repeat (8) dwell();
        @(negedge clk);
        check("redetect_strobes", strobes - s0, 1);
        check("redetect_out", {kp.row, kp.col, kp.key_held}, {4'b1000, 4'b0010, 1'b1});

        // ---- long hold (auto-repeat when compiled in) ----
        do_reset(16'h0100);           // key r2c0
        s0 = strobes;
        repeat (16) dwell();
        @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("hold_strobes", strobes - s0, 5);
`else
        check("hold_strobes", strobes - s0, 1);
`endif
        check("hold_out", {kp.row, kp.col, kp.key_held}, {4'b0100, 4'b0001, 1'b1});

        // ---- randomized against the reference model ----
        do_reset('0);
        s0 = strobes;
        begin
            int m_total;
            m_total = 0;
            for (int n = 0; n < 400; n++) begin
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 3))
                        0: pressed = '0;
                        3: pressed = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                        default: pressed = 16'h1 << $urandom_range(0, 15);
                    endcase
                end
                dwell();
                st = model_step(pressed);
                if (st) m_total++;
                er = (m_key >= 0) ? (4'b0001 << (m_key / 4)) : 4'b0000;
                ec = (m_key >= 0) ? (4'b0001 << (m_key % 4)) : 4'b0000;
                check($sformatf("rand%0d", n),
                      {kp.row_drive, kp.row, kp.col, kp.key_valid, kp.key_held},
                      {~(4'b0001 << m_idx), er, ec, st, (m_key >= 0)});
            end
            @(negedge clk);
            check("rand_strobe_total", strobes - s0, m_total);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
